sha512crypt_unit_dispatch: RTL and testbench
============================================

// Module: sha512crypt_unit_dispatch
// PURPOSE
// - Sequences candidate packets from the word generator / word list path into N_UNITS sha512crypt
//   computing units; sits between the candidate stream and the unit array, before the comparator.
// - Round-robin arbiter: locks one eligible unit for a whole packet, forwards the packet, tracks
//   per-unit pending acknowledgements, reports array idle status to the app_status logic.
// PARAMETERS
// - N_UNITS     4     number of computing units (2..16)
// - UNIT_W      2     clog2(N_UNITS), width of unit index
// - D_WIDTH     16    candidate stream data width
// - TIMEOUT_CYC 4096  pending-ack timeout in cycles (used only with SHA512CRYPT_DISPATCH_TIMEOUT_EN)
// PORTS
// - CLK        in   1        single clock; all logic on rising edge
// - rst_n      in   1        synchronous active-low reset
// - in_data    in   D_WIDTH  candidate stream word
// - in_valid   in   1        in_data valid
// - in_last    in   1        last word of packet (qualified by in_valid)
// - in_ready   out  1        word accepted when in_valid & in_ready
// - unit_idle  in   N_UNITS  unit i can take a new packet
// - unit_full  in   N_UNITS  unit i input buffer full (backpressure)
// - unit_wr_en out  N_UNITS  one-hot write strobe to granted unit
// - unit_dout  out  D_WIDTH  data broadcast to all units (= in_data, combinational)
// - unit_last  out  1        = in_last, combinational
// - cur_unit   out  UNIT_W   index of granted/last-granted unit
// - cores_idle out  1        registered: no transfer, no pending, all unit_idle high
// - err_timeout out 1        sticky timeout error (tied 0 without macro)
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, pending=0, rr_ptr=N_UNITS-1, cur_unit=0, cores_idle=0,
//   err_timeout=0, disabled=0; in_ready=0, unit_wr_en=0 combinationally while in IDLE.
//   Reset mid-packet abandons the packet; partially written unit gets no further strobes.
// - eligible[i] = unit_idle[i] & ~pending[i] & ~disabled[i].
// - IDLE: if in_valid & |eligible: grant = first eligible searching rr_ptr+1 upward, wrapping mod
//   N_UNITS; cur_unit<=grant; ->XFER. No in_valid or no eligible: stay, in_ready=0.
// - XFER: in_ready = ~unit_full[cur_unit]; unit_wr_en[cur_unit] = in_valid & in_ready, others 0.
//   On accepted word with in_last: pending[cur_unit]<=1, rr_ptr<=cur_unit, ->IDLE.
//   in_valid low in XFER: hold grant, no strobe. Grant never changes mid-packet.
// - Latency: first word of a packet transfers 1 cycle after IDLE sees in_valid & eligible;
//   1 word/cycle thereafter; 1 dead cycle between packets (IDLE re-arbitration).
// - pending[i] clears on first cycle unit_idle[i]=0 (unit consumed packet). Set and clear same
//   cycle for same unit: set wins (new packet just written).
// - cores_idle <= (state==IDLE) & ~in_valid & (pending==0) & (&unit_idle).
// - Single-word packet (in_valid & in_last on first XFER word) legal: one strobe.
// CONFIGURATION
// - SHA512CRYPT_DISPATCH_TIMEOUT_EN defined: per-unit counter runs while pending[i]=1, reset on
//   clear; reaching TIMEOUT_CYC-1: pending[i]<=0, disabled[i]<=1 (until reset), err_timeout<=1.
// - Not defined: no counters, disabled=0 constant, err_timeout tied 0; pending waits indefinitely.
// TESTING
// - Reset, all unit_idle=1, units drop idle 2 cyc after last; send 4 two-word packets ->
//   grants 0,1,2,3; unit_wr_en one-hot 0001,0010,0100,1000; 2 strobes each.
// - unit_idle[1]=0 held; send 4 packets -> grant order 0,2,3,0; unit 1 never strobed.
// - unit_full[cur_unit]=1 for 5 cycles mid 6-word packet -> in_ready=0 those 5 cycles,
//   exactly 6 strobes, data order preserved, grant unchanged.
// - unit_idle=0 all, in_valid=1 -> in_ready=0, stays IDLE; raise unit_idle[2] -> cur_unit=2,
//   first strobe next cycle.
// - rst_n=0 one cycle after 2nd word of 4-word packet -> unit_wr_en=0, pending=0, next grant 0.
// - With macro, TIMEOUT_CYC=16, unit 0 keeps unit_idle=1 after its packet -> err_timeout=1 16 cyc
//   after pending set; later packets go to units 1..3 only. Without macro err_timeout stays 0.

Source files
------------

// File: rtl/sha512crypt_unit_dispatch.sv
// sha512crypt_unit_dispatch
// Steers candidate packets from the word generator / word list stream into an
// array of N_UNITS sha512crypt units. A round-robin arbiter locks one eligible
// unit for a whole packet. A pending flag is kept for each unit until that unit
// shows it has consumed the packet. The block also reports when the whole array
// is idle.
//
// Optional feature: define SHA512CRYPT_DISPATCH_TIMEOUT_EN to enable the
// per-unit pending-acknowledge timeout. A unit that does not consume its packet
// within TIMEOUT_CYC cycles is disabled until reset, and err_timeout is raised.
//
// Ports
//   CLK          clock, all logic on rising edge
//   rst_n        synchronous active-low reset
//   in_data      candidate stream word
//   in_valid     in_data valid
//   in_last      last word of packet (qualified by in_valid)
//   in_ready     word accepted when in_valid & in_ready
//   unit_idle    per-unit: unit can take a new packet
//   unit_full    per-unit: unit input buffer full
//   unit_wr_en   one-hot write strobe to the granted unit
//   unit_dout    data broadcast to all units (combinational copy of in_data)
//   unit_last    combinational copy of in_last
//   cur_unit     index of the granted / last-granted unit
//   cores_idle   registered: no transfer, nothing pending, all units idle
//   err_timeout  sticky timeout error (0 when the timeout feature is absent)
module sha512crypt_unit_dispatch #(
    parameter int N_UNITS     = 4,
    parameter int UNIT_W      = 2,
    parameter int D_WIDTH     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic [N_UNITS-1:0] unit_idle,
    input  logic [N_UNITS-1:0] unit_full,
    output logic [N_UNITS-1:0] unit_wr_en,
    output logic [D_WIDTH-1:0] unit_dout,
    output logic               unit_last,
    output logic [UNIT_W-1:0]  cur_unit,
    output logic               cores_idle,
    output logic               err_timeout
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]         r_state;
    logic [N_UNITS-1:0] r_pending;
    logic [UNIT_W-1:0]  r_rr_ptr;
    logic [UNIT_W-1:0]  r_cur_unit;
    logic               r_cores_idle;

    logic [N_UNITS-1:0] w_disabled;
    logic [N_UNITS-1:0] w_timeout_clr;
    logic [N_UNITS-1:0] w_eligible;
    logic [UNIT_W-1:0]  w_grant;
    logic               w_found;
    logic               w_ready;
    logic               w_accept;
    logic               w_done;
    logic [N_UNITS-1:0] w_cur_onehot;
    logic [N_UNITS-1:0] w_pending_nxt;

    assign w_eligible   = unit_idle & ~r_pending & ~w_disabled;
    assign w_cur_onehot = N_UNITS'(1) << r_cur_unit;
    assign w_ready      = (r_state == S_XFER) && !unit_full[r_cur_unit];
    assign w_accept     = w_ready && in_valid;
    assign w_done       = w_accept && in_last;

    // Round-robin search starting just after the last granted unit.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_UNITS; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % N_UNITS;
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_grant = UNIT_W'(idx);
            end
        end
    end

    // A unit dropping idle means it took its packet. A set for a unit that was
    // just written overrides a clear in the same cycle.
    assign w_pending_nxt = ((r_pending & unit_idle) & ~w_timeout_clr)
                         | (w_done ? w_cur_onehot : '0);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_rr_ptr     <= UNIT_W'(N_UNITS - 1);
            r_cur_unit   <= '0;
            r_cores_idle <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_cores_idle <= (r_state == S_IDLE) && !in_valid
                            && (r_pending == '0) && (&unit_idle);
            case (r_state)
                S_IDLE: begin
                    if (in_valid && w_found) begin
                        r_cur_unit <= w_grant;
                        r_state    <= S_XFER;
                    end
                end
                default: begin
                    // The grant stays locked until the last word is accepted.
                    if (w_done) begin
                        r_rr_ptr <= r_cur_unit;
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SHA512CRYPT_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0]   r_cnt [N_UNITS];
    logic [N_UNITS-1:0] r_disabled;
    logic               r_err_timeout;

    always_comb begin
        w_timeout_clr = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            w_timeout_clr[i] = r_pending[i] && (r_cnt[i] == CNT_W'(TIMEOUT_CYC - 1));
        end
    end

    // The counter ages only a packet that is still unacknowledged. It restarts
    // whenever the pending flag clears, either by consumption or by timeout.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < N_UNITS; i++) begin
                r_cnt[i] <= '0;
            end
            r_disabled    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (r_pending[i] && unit_idle[i] && !w_timeout_clr[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    r_cnt[i] <= '0;
                end
            end
            r_disabled    <= r_disabled | w_timeout_clr;
            r_err_timeout <= r_err_timeout | (|w_timeout_clr);
        end
    end

    assign w_disabled  = r_disabled;
    assign err_timeout = r_err_timeout;
`else
    assign w_timeout_clr = '0;
    assign w_disabled    = '0;
    assign err_timeout   = 1'b0;
`endif

    assign in_ready   = w_ready;
    assign unit_wr_en = w_accept ? w_cur_onehot : '0;
    assign unit_dout  = in_data;
    assign unit_last  = in_last;
    assign cur_unit   = r_cur_unit;
    assign cores_idle = r_cores_idle;

endmodule

// File: tb/tb_sha512crypt_unit_dispatch.sv
// Directed bench for sha512crypt_unit_dispatch. It includes a small model of
// the unit array. After a unit receives the last word of a packet, the unit
// stays idle for 2 more cycles, is busy for 3 cycles, and then becomes idle
// again. A unit can be told never to consume, so that it stays idle forever.
module tb_sha512crypt_unit_dispatch;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [3:0]  unit_idle;
    logic [3:0]  unit_full;
    logic [3:0]  unit_wr_en;
    logic [15:0] unit_dout;
    logic        unit_last;
    logic [1:0]  cur_unit;
    logic        cores_idle;
    logic        err_timeout;

    logic [3:0]  idle_mask;
    logic [3:0]  no_consume;
    logic [3:0]  model_idle;
    int          busy_cnt [4];

    int n_cmp = 0;
    int n_err = 0;

    // Outputs of the packet driver.
    int          d_strobes;
    logic [3:0]  d_wr_or;
    logic        d_bad;
    int          d_nrdy;
    logic        d_tmo;

    always #5 CLK = ~CLK;

    sha512crypt_unit_dispatch #(
        .N_UNITS(4), .UNIT_W(2), .D_WIDTH(16), .TIMEOUT_CYC(16)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .unit_idle(unit_idle),
        .unit_full(unit_full), .unit_wr_en(unit_wr_en), .unit_dout(unit_dout),
        .unit_last(unit_last), .cur_unit(cur_unit), .cores_idle(cores_idle),
        .err_timeout(err_timeout)
    );

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) busy_cnt[i] <= 0;
            else if (unit_wr_en[i] && unit_last && !no_consume[i]) busy_cnt[i] <= 5;
            else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
        end
    end

    always_comb begin
        model_idle = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (busy_cnt[i] >= 1 && busy_cnt[i] <= 3) model_idle[i] = 1'b0;
        end
    end

    assign unit_idle = model_idle & idle_mask;

    // Drives one packet of n words, base, base+1, ... The bench holds unit_full
    // high during driver cycles [fs, fs+fl). Word 0 is offered in driver cycle 0.
    task automatic send_pkt(input int n, input logic [15:0] base, input int fs, input int fl);
        int i;
        int cyc;
        logic [1:0] first_cu;
        i = 0; cyc = 0; first_cu = '0;
        d_strobes = 0; d_wr_or = '0; d_bad = 1'b0; d_nrdy = 0; d_tmo = 1'b0;
        while (i < n && cyc < 60) begin
            @(negedge CLK);
            in_valid  = 1'b1;
            in_data   = base + 16'(i);
            in_last   = (i == n - 1);
            unit_full = (cyc >= fs && cyc < fs + fl) ? 4'hF : 4'h0;
            #1;
            if (unit_full != 4'h0 && !in_ready) d_nrdy++;
            if (in_ready) begin
                d_strobes++;
                d_wr_or |= unit_wr_en;
                if (unit_dout !== base + 16'(i) || $countones(unit_wr_en) != 1
                    || unit_last !== (i == n - 1)) d_bad = 1'b1;
                if (d_strobes == 1) first_cu = cur_unit;
                else if (cur_unit !== first_cu) d_bad = 1'b1;
                i++;
            end
            cyc++;
        end
        d_tmo = (i < n);
        @(posedge CLK);
        #1;
        in_valid = 1'b0; in_last = 1'b0; unit_full = 4'h0;
    endtask

    task automatic settle();
        repeat (10) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        unit_full = '0; idle_mask = 4'hF; no_consume = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_cmp++; if (unit_wr_en !== 4'h0) begin n_err++; $display("FAIL reset_wr_en got %b want 0000", unit_wr_en); end
        n_cmp++; if (cur_unit !== 2'd0) begin n_err++; $display("FAIL reset_cur_unit got %0d want 0", cur_unit); end
        n_cmp++; if (cores_idle !== 1'b0) begin n_err++; $display("FAIL reset_cores_idle got %b want 0", cores_idle); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_timeout); end
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if (cores_idle !== 1'b1) begin n_err++; $display("FAIL idle_after_reset got %b want 1", cores_idle); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp [4];
        exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b0100; exp[3] = 4'b1000;
        for (int p = 0; p < 4; p++) begin
            send_pkt(2, 16'h1000 + 16'(p * 16), 0, 0);
            n_cmp++; if (d_wr_or !== exp[p]) begin n_err++; $display("FAIL rr_grant%0d got %b want %b", p, d_wr_or, exp[p]); end
            n_cmp++; if (d_strobes != 2) begin n_err++; $display("FAIL rr_strobes%0d got %0d want 2", p, d_strobes); end
            n_cmp++; if (d_bad || d_tmo) begin n_err++; $display("FAIL rr_data%0d got bad=%b tmo=%b want 0 0", p, d_bad, d_tmo); end
        end
    endtask

    task automatic test_skip_busy();
        logic [3:0] exp [4];
        exp[0] = 4'b0001; exp[1] = 4'b0100; exp[2] = 4'b1000; exp[3] = 4'b0001;
        idle_mask = 4'b1101;
        for (int p = 0; p < 4; p++) begin
            send_pkt(2, 16'h2000 + 16'(p * 16), 0, 0);
            n_cmp++; if (d_wr_or !== exp[p]) begin n_err++; $display("FAIL skip_grant%0d got %b want %b", p, d_wr_or, exp[p]); end
            n_cmp++; if (d_strobes != 2 || d_bad || d_tmo) begin n_err++; $display("FAIL skip_xfer%0d got strobes=%0d bad=%b want 2 0", p, d_strobes, d_bad); end
        end
        idle_mask = 4'hF;
    endtask

    task automatic test_backpressure();
        send_pkt(6, 16'h3000, 3, 5);
        n_cmp++; if (d_nrdy != 5) begin n_err++; $display("FAIL bp_stall got %0d want 5", d_nrdy); end
        n_cmp++; if (d_strobes != 6) begin n_err++; $display("FAIL bp_strobes got %0d want 6", d_strobes); end
        n_cmp++; if (d_wr_or !== 4'b0010) begin n_err++; $display("FAIL bp_grant got %b want 0010", d_wr_or); end
        n_cmp++; if (d_bad || d_tmo) begin n_err++; $display("FAIL bp_order got bad=%b tmo=%b want 0 0", d_bad, d_tmo); end
    endtask

    task automatic test_no_eligible();
        idle_mask = 4'h0;
        @(negedge CLK);
        in_valid = 1'b1; in_data = 16'h4444; in_last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0 || unit_wr_en !== 4'h0) begin n_err++; $display("FAIL noelig_wait%0d got rdy=%b wr=%b want 0 0000", c, in_ready, unit_wr_en); end
            @(negedge CLK);
        end
        idle_mask = 4'b0100;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL noelig_arb got rdy=%b want 0", in_ready); end
        @(negedge CLK);
        #1;
        n_cmp++; if (cur_unit !== 2'd2) begin n_err++; $display("FAIL noelig_cur got %0d want 2", cur_unit); end
        n_cmp++; if (unit_wr_en !== 4'b0100) begin n_err++; $display("FAIL noelig_strobe got %b want 0100", unit_wr_en); end
        @(posedge CLK);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge CLK);
        #1;
        n_cmp++; if (unit_wr_en !== 4'h0 || in_ready !== 1'b0) begin n_err++; $display("FAIL single_word_end got wr=%b rdy=%b want 0000 0", unit_wr_en, in_ready); end
        idle_mask = 4'hF;
    endtask

    task automatic test_reset_mid_packet();
        int acc;
        int cyc;
        logic [3:0] w;
        acc = 0; cyc = 0; w = '0;
        in_last = 1'b0;
        while (acc < 2 && cyc < 20) begin
            @(negedge CLK);
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(acc);
            #1;
            if (in_ready) begin
                if (acc == 0) w = unit_wr_en;
                acc++;
            end
            cyc++;
        end
        n_cmp++; if (acc != 2 || w !== 4'b1000) begin n_err++; $display("FAIL mid_start got words=%0d wr=%b want 2 1000", acc, w); end
        @(negedge CLK);
        in_data = 16'hA002;
        rst_n = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++; if (unit_wr_en !== 4'h0 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_abort got wr=%b rdy=%b want 0000 0", unit_wr_en, in_ready); end
        n_cmp++; if (cur_unit !== 2'd0) begin n_err++; $display("FAIL mid_cur got %0d want 0", cur_unit); end
        @(negedge CLK);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++; if (cores_idle !== 1'b1) begin n_err++; $display("FAIL mid_pending got cores_idle=%b want 1", cores_idle); end
        send_pkt(1, 16'hB000, 0, 0);
        n_cmp++; if (d_wr_or !== 4'b0001 || d_strobes != 1 || d_bad || d_tmo) begin n_err++; $display("FAIL mid_next got wr=%b strobes=%0d want 0001 1", d_wr_or, d_strobes); end
    endtask

    task automatic test_timeout();
        logic [3:0] exp [4];
        logic exp_err;
`ifdef SHA512CRYPT_DISPATCH_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        exp[0] = 4'b0010; exp[1] = 4'b0100; exp[2] = 4'b1000; exp[3] = 4'b0010;
        @(negedge CLK);
        rst_n = 1'b0;
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        no_consume = 4'b0001;
        send_pkt(1, 16'hC000, 0, 0);
        n_cmp++; if (d_wr_or !== 4'b0001 || d_strobes != 1) begin n_err++; $display("FAIL to_first got wr=%b strobes=%0d want 0001 1", d_wr_or, d_strobes); end
        repeat (15) @(posedge CLK);
        #1;
        n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_early got %b want 0", err_timeout); end
        @(posedge CLK);
        #1;
        n_cmp++; if (err_timeout !== exp_err) begin n_err++; $display("FAIL to_fire got %b want %b", err_timeout, exp_err); end
        for (int p = 0; p < 4; p++) begin
            send_pkt(2, 16'hD000 + 16'(p * 16), 0, 0);
            n_cmp++; if (d_wr_or !== exp[p] || d_strobes != 2 || d_tmo) begin n_err++; $display("FAIL to_grant%0d got %b want %b", p, d_wr_or, exp[p]); end
        end
        n_cmp++; if (err_timeout !== exp_err) begin n_err++; $display("FAIL to_sticky got %b want %b", err_timeout, exp_err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        settle();
        test_skip_busy();
        settle();
        test_backpressure();
        settle();
        test_no_eligible();
        settle();
        test_reset_mid_packet();
        settle();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
